// File: rtl/graying_ctrl.sv
// Frame sequencer for the graying point-operation core.
// Feeds the core one frame of pixels and forwards only tagged, genuine results.
module graying_ctrl #(
    parameter int color_width = 8,
    parameter int core_lat    = 2,
    parameter int warm_cycles = 1,
    parameter int dim_width   = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [dim_width-1:0]     cfg_width,
    input  logic [dim_width-1:0]     cfg_height,
    input  logic                     s_valid,
    input  logic [3*color_width-1:0] s_data,
    output logic                     s_ready,
    output logic                     core_enable,
    output logic [3*color_width-1:0] core_data,
    input  logic                     core_ready,
    input  logic [color_width-1:0]   core_result,
    output logic                     m_valid,
    output logic [color_width-1:0]   m_data,
    output logic                     m_eol,
    output logic                     m_eof,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int CNT_W  = 2 * dim_width;
    localparam int WARM_W = (warm_cycles > 1) ? $clog2(warm_cycles) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WARM,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [dim_width-1:0] width_q;
    logic [dim_width-1:0] height_q;
    logic [dim_width-1:0] x_cnt;
    logic [dim_width-1:0] y_cnt;
    logic [CNT_W-1:0]     total_q;
    logic [CNT_W-1:0]     in_cnt;
    logic [WARM_W-1:0]    warm_cnt;
    logic [core_lat-1:0]  tag;
    logic [core_lat-1:0]  tag_shift;
    logic [core_lat-1:0]  tag_nxt;
    logic                 accept;
    logic                 start_ok;
    logic                 last_in;
    logic                 warm_end;
    logic                 x_last;
    logic                 y_last;

    always_comb begin
        accept    = (state == RUN) && s_valid;
        start_ok  = (state == IDLE) && start
                    && (cfg_width != '0) && (cfg_height != '0);
        last_in   = (in_cnt + CNT_W'(1)) == total_q;
        warm_end  = core_ready
                    || (warm_cnt == WARM_W'(warm_cycles - 1));
        tag_shift = tag << 1;
        tag_nxt   = tag_shift;
        tag_nxt[0] = accept;
        x_last    = x_cnt == (width_q - dim_width'(1));
        y_last    = y_cnt == (height_q - dim_width'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = start_ok ? WARM : DONE;
                end
            end
            WARM: begin
                if (warm_end) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (accept && last_in) begin
                    state_nxt = DRAIN;
                end
            end
            // Leave once the last tagged result has shifted out.
            DRAIN: begin
                if (tag_shift == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q   <= '0;
            height_q  <= '0;
            total_q   <= '0;
            in_cnt    <= '0;
            warm_cnt  <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            tag       <= '0;
            core_data <= '0;
        end else begin
            tag <= tag_nxt;
            if (start_ok) begin
                width_q  <= cfg_width;
                height_q <= cfg_height;
                total_q  <= CNT_W'(cfg_width) * CNT_W'(cfg_height);
                in_cnt   <= '0;
                warm_cnt <= '0;
                x_cnt    <= '0;
                y_cnt    <= '0;
            end
            if (state == WARM) begin
                warm_cnt <= warm_cnt + WARM_W'(1);
            end
            if (accept) begin
                core_data <= s_data;
                in_cnt    <= in_cnt + CNT_W'(1);
            end
            if (m_valid) begin
                if (x_last) begin
                    x_cnt <= '0;
                    y_cnt <= y_last ? '0 : y_cnt + dim_width'(1);
                end else begin
                    x_cnt <= x_cnt + dim_width'(1);
                end
            end
        end
    end

    assign s_ready     = (state == RUN);
    assign core_enable = (state == WARM) || (state == RUN)
                         || (state == DRAIN);
    assign busy        = (state != IDLE);
    assign frame_done  = (state == DONE);
    assign m_valid     = tag[core_lat-1] && core_ready;
    assign m_data      = m_valid ? core_result : '0;
    assign m_eol       = m_valid && x_last;
    assign m_eof       = m_valid && x_last && y_last;

endmodule

// File: tb/tb_graying_ctrl.sv
// Directed bench for graying_ctrl with a behavioural graying core model.
// Vectors carry hand-computed grey values; multi-cycle corners are sequences.
module tb_graying_ctrl;

    localparam int CW   = 8;
    localparam int DW   = 12;
    localparam int LAT  = 2;
    localparam int WARM = 1;

    typedef struct {
        logic [23:0] pix;
        logic [7:0]  grey;
        logic        eol;
        logic        eof;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       eol;
        logic       eof;
        int         cyc;
    } out_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] cfg_width = '0;
    logic [DW-1:0] cfg_height = '0;
    logic          s_valid = 1'b0;
    logic [23:0]   s_data = '0;
    logic          s_ready;
    logic          core_enable;
    logic [23:0]   core_data;
    logic          core_ready;
    logic [7:0]    core_result;
    logic          m_valid;
    logic [7:0]    m_data;
    logic          m_eol;
    logic          m_eof;
    logic          busy;
    logic          frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int busy_cnt = 0;
    int ready_cnt = 0;
    int en_at_done = 0;
    int bad_idle = 0;
    int wcnt;
    int acc_q[$];
    out_t mq[$];
    vec_t cur[$];
    vec_t v2x2[4];
    vec_t v4x1[4];

    graying_ctrl #(
        .color_width(CW),
        .core_lat(LAT),
        .warm_cycles(WARM),
        .dim_width(DW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .cfg_width(cfg_width),
        .cfg_height(cfg_height),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .core_enable(core_enable),
        .core_data(core_data),
        .core_ready(core_ready),
        .core_result(core_result),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_eol(m_eol),
        .m_eof(m_eof),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] grey(input logic [23:0] p);
        logic [15:0] s;
        s = 16'(p[23:16]) * 16'd77 + 16'(p[15:8]) * 16'd150
            + 16'(p[7:0]) * 16'd29;
        return s[15:8];
    endfunction

    // Core: one result register behind core_data, ready after WARM enables.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_ready  <= 1'b0;
            core_result <= '0;
            wcnt        <= 0;
        end else if (!core_enable) begin
            core_ready  <= 1'b0;
            core_result <= '0;
            wcnt        <= 0;
        end else begin
            core_result <= grey(core_data);
            wcnt        <= wcnt + 1;
            core_ready  <= (wcnt + 1 >= WARM);
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (m_valid) mq.push_back('{m_data, m_eol, m_eof, cyc});
            if (s_valid && s_ready) acc_q.push_back(cyc);
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                if (core_enable) en_at_done++;
            end
            if (busy) busy_cnt++;
            if (s_ready) ready_cnt++;
            if (!m_valid && (m_data != 0 || m_eol || m_eof)) bad_idle++;
        end
    end

    function automatic logic [63:0] outs();
        return {s_ready, core_enable, core_data, m_valid, m_data,
                m_eol, m_eof, busy, frame_done};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        mq.delete();
        acc_q.delete();
        done_cnt = 0;
        busy_cnt = 0;
        ready_cnt = 0;
        en_at_done = 0;
        bad_idle = 0;
    endtask

    task automatic start_frame(input int w, input int h);
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_width = DW'(w);
        cfg_height = DW'(h);
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input string name, input int n, input bit toggle,
                        input int mid_start);
        int idx = 0;
        int t = 0;
        bit acc;
        bit pulsed = 1'b0;
        while (idx < n && t < 300) begin
            s_valid = toggle ? ~t[0] : 1'b1;
            s_data = s_valid ? cur[idx].pix : 24'hABCDEF;
            if (idx == mid_start && !pulsed) begin
                start = 1'b1;
                cfg_width = 8;
                cfg_height = 8;
                pulsed = 1'b1;
            end
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (acc) idx++;
            t++;
        end
        check({name, "_sent"}, idx, n);
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (done_cnt == 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        check(name, done_cnt, 1);
    endtask

    task automatic check_frame(input string name);
        check({name, "_count"}, mq.size(), cur.size());
        check({name, "_accepts"}, acc_q.size(), cur.size());
        for (int i = 0; i < mq.size() && i < cur.size(); i++) begin
            check($sformatf("%s_data%0d", name, i), mq[i].d, cur[i].grey);
            check($sformatf("%s_eol%0d", name, i), mq[i].eol, cur[i].eol);
            check($sformatf("%s_eof%0d", name, i), mq[i].eof, cur[i].eof);
            if (i < acc_q.size())
                check($sformatf("%s_lat%0d", name, i),
                      mq[i].cyc - acc_q[i], LAT);
        end
        check({name, "_idle_clean"}, bad_idle, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        v2x2[0] = '{24'hFFFFFF, 8'hFF, 1'b0, 1'b0};
        v2x2[1] = '{24'h000000, 8'h00, 1'b1, 1'b0};
        v2x2[2] = '{24'hFF0000, 8'h4C, 1'b0, 1'b0};
        v2x2[3] = '{24'h0000FF, 8'h1C, 1'b1, 1'b1};
        v4x1[0] = '{24'h00FF00, 8'h95, 1'b0, 1'b0};
        v4x1[1] = '{24'h808080, 8'h80, 1'b0, 1'b0};
        v4x1[2] = '{24'hFF0000, 8'h4C, 1'b0, 1'b0};
        v4x1[3] = '{24'h0000FF, 8'h1C, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", outs(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 2x2 frame, s_valid held high
        clear_mon();
        cur.delete();
        foreach (v2x2[i]) cur.push_back(v2x2[i]);
        start_frame(2, 2);
        check("warm_outs", {busy, core_enable, s_ready}, 3'b110);
        send("f1", 4, 1'b0, -1);
        wait_done("f1_done");
        s_valid = 1'b0;
        check_frame("f1");
        if (mq.size() >= 4) check("f1_consec", mq[3].cyc - mq[0].cyc, 3);
        else check("f1_consec_count", mq.size(), 4);

        // 4x1 frame, s_valid toggling
        clear_mon();
        cur.delete();
        foreach (v4x1[i]) cur.push_back(v4x1[i]);
        start_frame(4, 1);
        send("f2", 4, 1'b1, -1);
        s_valid = 1'b0;
        wait_done("f2_done");
        check_frame("f2");
        for (int i = 1; i < 4 && i < mq.size() && i < acc_q.size(); i++)
            check($sformatf("f2_gap%0d", i), mq[i].cyc - mq[i-1].cyc,
                  acc_q[i] - acc_q[i-1]);

        // empty frame: width 0
        clear_mon();
        s_valid = 1'b1;
        start_frame(0, 5);
        wait_done("z_done");
        s_valid = 1'b0;
        check("z_ready", ready_cnt, 0);
        check("z_mvalid", mq.size(), 0);
        check("z_busy", busy_cnt, 1);
        check("z_done_lat", (done_cyc - start_cyc >= 1)
                            && (done_cyc - start_cyc <= 2), 1);

        // 3x3 frame with a stray 8x8 start mid-frame
        clear_mon();
        cur.delete();
        for (int i = 0; i < 9; i++) begin
            vec_t v;
            v.pix = {8'(i * 28), 8'(255 - i * 20), 8'(i * 7 + 3)};
            v.grey = grey(v.pix);
            v.eol = (i % 3 == 2);
            v.eof = (i == 8);
            cur.push_back(v);
        end
        start_frame(3, 3);
        send("f4", 9, 1'b0, 4);
        s_valid = 1'b0;
        wait_done("f4_done");
        check_frame("f4");
        repeat (20) @(posedge clk);
        #1;
        check("f4_no_extra", mq.size(), 9);
        check("f4_single_done", done_cnt, 1);
        check("f4_idle", busy, 0);

        // reset after the 2nd accept of a 3x3 frame
        clear_mon();
        start_frame(3, 3);
        send("f5", 2, 1'b0, -1);
        s_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("f5_rst_outs", outs(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_mon();
        repeat (6) @(posedge clk);
        #1;
        check("f5_no_mvalid", mq.size(), 0);
        check("f5_idle", busy_cnt, 0);

        // 1x1 frame
        clear_mon();
        cur.delete();
        cur.push_back('{24'hFF0000, 8'h4C, 1'b1, 1'b1});
        start_frame(1, 1);
        send("f6", 1, 1'b0, -1);
        s_valid = 1'b0;
        wait_done("f6_done");
        check_frame("f6");
        check("f6_en_in_done", en_at_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
